// File: rtl/rf_pkg.sv
// Shared types and helpers for the rf_mp multi-port register file.
package rf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set beats clear, bulk clear beats both.
module rf_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_all,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [DEPTH-1:0]         clr_mask,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_pend
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] set_mask;

  always_comb begin
    set_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
  end

  // A new reservation in the same cycle as a completing write means a newer producer exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (clr_all) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    look_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      look_pend[i] = pend[look_addr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port register file with scoreboard and sequenced soft clear.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module rf_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  clr_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic [NUM_WR-1:0] wr_acc;
  logic              rsv_acc;
  logic [DEPTH-1:0]  wr_clr_mask;
  logic [NUM_RD-1:0] sb_pend;

  assign idle     = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign rsv_acc  = idle && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Accepted writes: only outside a clear, and never to the hardwired zero entry.
  always_comb begin
    wr_acc      = '0;
    wr_clr_mask = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_acc[p] = idle && wr_en[p] &&
                  !((ZERO_REG != 0) && (wr_addr[p*ADDR_W +: ADDR_W] == '0));
      if (wr_acc[p]) wr_clr_mask[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Later write ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_acc[p]) mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_all   (idle && clr_req),
    .set_en    (rsv_acc),
    .set_addr  (rsv_addr),
    .clr_mask  (wr_clr_mask),
    .look_addr (rd_addr),
    .look_pend (sb_pend)
  );

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
        rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
        rd_pend[i]                  = sb_pend[i];
`ifdef RF_BYPASS_EN
        // wr_acc already excludes CLEAR and the zero entry, so bypass inherits both rules.
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_acc[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data[i*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
            rd_pend[i] = rsv_acc && (rsv_addr == rd_addr[i*ADDR_W +: ADDR_W]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: directed scenarios plus randomized traffic against an array model.
module tb_rf_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     clr_req;
  logic                     clr_busy;

  always #5 clk = ~clk;

  rf_mp #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] ra [NUM_RD];
  logic              we [NUM_WR];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic              rsv;
  logic [ADDR_W-1:0] rsva;
  logic              clr;

  // Reference model: plain storage, pending flags, and the number of entries already wiped.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_pend [DEPTH];
  bit                m_clearing;
  int                m_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (!m_clearing)
      for (int p = 0; p < NUM_WR; p++) if (we[p] && wa[p] == a) v = wd[p];
`endif
    return v;
  endfunction

  function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
    logic v;
    if (a == 0) return 1'b0;
    v = m_pend[a];
`ifdef RF_BYPASS_EN
    if (!m_clearing)
      for (int p = 0; p < NUM_WR; p++) if (we[p] && wa[p] == a) v = rsv && (rsva == a);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_idx      = 0;
  endtask

  task automatic model_update();
    if (m_clearing) begin
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) m_clearing = 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wa[p] != 0) begin
          m_mem[wa[p]]  = wd[p];
          m_pend[wa[p]] = 1'b0;
        end
      end
      if (rsv && rsva != 0) m_pend[rsva] = 1'b1;
      if (clr) begin
        m_clearing = 1'b1;
        m_idx      = 0;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < NUM_RD; i++) ra[i] = ADDR_W'($urandom_range(DEPTH - 1));
    for (int p = 0; p < NUM_WR; p++) begin
      we[p] = 1'b0;
      wa[p] = '0;
      wd[p] = '0;
    end
    rsv  = 1'b0;
    rsva = '0;
    clr  = 1'b0;
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*ADDR_W +: ADDR_W] = ra[i];
    for (int p = 0; p < NUM_WR; p++) begin
      wr_en[p]                    = we[p];
      wr_addr[p*ADDR_W +: ADDR_W] = wa[p];
      wr_data[p*DATA_W +: DATA_W] = wd[p];
    end
    rsv_en   = rsv;
    rsv_addr = rsva;
    clr_req  = clr;
    #1;
  endtask

  task automatic check_output();
    for (int i = 0; i < NUM_RD; i++) begin
      check($sformatf("rd_data%0d@%0d", i, ra[i]), 64'(rd_data[i*DATA_W +: DATA_W]), 64'(exp_data(ra[i])));
      check($sformatf("rd_pend%0d@%0d", i, ra[i]), 64'(rd_pend[i]), 64'(exp_pend(ra[i])));
    end
    check("clr_busy", 64'(clr_busy), 64'(m_clearing));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cycle();
    apply_stimulus();
    check_output();
    advance();
  endtask

  logic [DATA_W-1:0] bypass_exp;

  initial begin
    rst_n = 1'b0;
    set_idle();
    ra[0] = 5'd5;
    ra[1] = 5'd31;
    model_reset();
    @(negedge clk);
    apply_stimulus();
    check("reset_clr_busy", 64'(clr_busy), 64'd0);
    check("reset_rd_pend", 64'(rd_pend), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write then read entry 5");
    set_idle();
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    ra[0] = 5'd5; ra[1] = 5'd5;
    cycle();
    set_idle();
    ra[0] = 5'd5; ra[1] = 5'd5;
    apply_stimulus();
    check_output();
    check("e5_port1", 64'(rd_data[DATA_W +: DATA_W]), 64'h0000_0000_DEAD_BEEF);
    check("e5_pend", 64'(rd_pend), 64'd0);
    advance();

    $display("[TB] writes to the zero entry are dropped");
    set_idle();
    we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'h1234;
    ra[0] = 5'd0; ra[1] = 5'd0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_idle();
      ra[0] = 5'd0; ra[1] = 5'd0;
      apply_stimulus();
      check_output();
      check("zero_entry", 64'(rd_data), 64'd0);
      advance();
    end

    $display("[TB] dual write collision on entry 7");
    set_idle();
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hAAAA;
    we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h5555;
    cycle();
    set_idle();
    ra[0] = 5'd7;
    apply_stimulus();
    check_output();
    check("collide_e7", 64'(rd_data[DATA_W-1:0]), 64'h5555);
    advance();

    $display("[TB] reservation scoreboard on entry 3");
    set_idle();
    rsv = 1'b1; rsva = 5'd3;
    cycle();
    set_idle();
    ra[0] = 5'd3;
    apply_stimulus();
    check_output();
    check("pend_after_rsv", 64'(rd_pend[0]), 64'd1);
    advance();
    set_idle();
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h3333;
    cycle();
    set_idle();
    ra[0] = 5'd3;
    apply_stimulus();
    check_output();
    check("pend_after_wr", 64'(rd_pend[0]), 64'd0);
    advance();
    set_idle();
    we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h4444;
    rsv = 1'b1; rsva = 5'd3;
    cycle();
    set_idle();
    ra[0] = 5'd3;
    apply_stimulus();
    check_output();
    check("pend_rsv_and_wr", 64'(rd_pend[0]), 64'd1);
    advance();

    $display("[TB] fill and soft clear");
    for (int e = 0; e < DEPTH; e += 2) begin
      set_idle();
      we[0] = 1'b1; wa[0] = ADDR_W'(e);     wd[0] = 32'h1000_0000 | DATA_W'(e);
      we[1] = 1'b1; wa[1] = ADDR_W'(e + 1); wd[1] = 32'h1000_0000 | DATA_W'(e + 1);
      rsv = 1'b1; rsva = ADDR_W'($urandom_range(DEPTH - 1));
      cycle();
    end
    set_idle();
    clr = 1'b1;
    cycle();
    for (int k = 1; k <= DEPTH; k++) begin
      set_idle();
      ra[0] = ADDR_W'(k - 1);
      ra[1] = 5'd31;
      if (k == 10) begin
        we[1] = 1'b1; wa[1] = 5'd31; wd[1] = 32'hBAD0_BAD0;
      end
      rsv  = ($urandom_range(1) == 1);
      rsva = ADDR_W'($urandom_range(DEPTH - 1));
      clr  = (k == 5);
      apply_stimulus();
      check_output();
      check("busy_during_clear", 64'(clr_busy), 64'd1);
      advance();
    end
    for (int e = 0; e < DEPTH; e += 2) begin
      set_idle();
      ra[0] = ADDR_W'(e);
      ra[1] = ADDR_W'(e + 1);
      apply_stimulus();
      check_output();
      check("cleared_data", 64'(rd_data), 64'd0);
      check("cleared_pend", 64'(rd_pend), 64'd0);
      check("busy_after_clear", 64'(clr_busy), 64'd0);
      advance();
    end

    $display("[TB] same-cycle write and read of entry 9");
    set_idle();
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h1111;
    cycle();
    set_idle();
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hCAFE;
    ra[0] = 5'd9;
`ifdef RF_BYPASS_EN
    bypass_exp = 32'hCAFE;
`else
    bypass_exp = 32'h1111;
`endif
    apply_stimulus();
    check_output();
    check("same_cycle_e9", 64'(rd_data[DATA_W-1:0]), 64'(bypass_exp));
    advance();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      set_idle();
      for (int p = 0; p < NUM_WR; p++) begin
        we[p] = ($urandom_range(1) == 1);
        wa[p] = ADDR_W'($urandom_range(DEPTH - 1));
        wd[p] = $urandom;
      end
      if ($urandom_range(3) == 0) ra[0] = wa[0];
      rsv  = ($urandom_range(2) == 0);
      rsva = ADDR_W'($urandom_range(DEPTH - 1));
      clr  = ($urandom_range(39) == 0);
      cycle();
    end

    $display("[TB] reset in the middle of a clear");
    set_idle();
    clr = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      set_idle();
      cycle();
    end
    set_idle();
    rst_n = 1'b0;
    apply_stimulus();
    model_reset();
    check("midclr_busy", 64'(clr_busy), 64'd0);
    check("midclr_data", 64'(rd_data), 64'd0);
    check("midclr_pend", 64'(rd_pend), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      set_idle();
      we[0] = 1'b1;
      wa[0] = ADDR_W'($urandom_range(DEPTH - 1));
      wd[0] = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port register file; next generation of the core's 32x32 2R1W register file.
- Generalised in data width, depth, read-port count and write-port count.
- Adds a hardwired-zero entry, a pending-write scoreboard for hazard detection and a sequenced soft-clear engine.
- Sits in the decode/writeback path of the pipelined core; decode reads operands and reserves destinations, writeback writes results.

Parameters:
- DATA_W, 32, entry width in bits
- DEPTH, 32, number of entries (power of two, >=4)
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes and is never pending

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i (ADDR_W = $clog2(DEPTH))
- rd_data  out  NUM_RD*DATA_W  read data, port i at slice i
- rd_pend  out  NUM_RD  1 = addressed entry has an outstanding reservation
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve (mark pending) one entry
- rsv_addr  in  ADDR_W  entry to reserve
- clr_req  in  1  start a soft clear
- clr_busy  out  1  soft clear in progress

Behaviour:
- Reset (rst_n low, asynchronous): all entries 0, all pending bits 0, FSM IDLE, clear counter 0.
- Reset outputs: clr_busy=0, rd_pend=0, rd_data=0.
- Reset asserted mid-clear aborts the clear immediately.
- Reads: combinational, zero latency; rd_data[i] = array[rd_addr[i]].
- Reads when ZERO_REG=1: address 0 returns 0.
- Writes: take effect at the rising edge, visible on reads the next cycle.
- Writes to address 0 are dropped when ZERO_REG=1.
- Two write ports to the same address in one cycle: the higher port index wins.
- Scoreboard: one pending bit per entry.
- Scoreboard set: rsv_en sets pend[rsv_addr] at the edge.
- Scoreboard clear: any accepted write clears pend[wr_addr].
- Reserve and write to the same address in one cycle: pending ends up set (the new producer wins).
- rd_pend[i] = pend[rd_addr[i]], combinational.
- Clear FSM, states IDLE, CLEAR:
  - IDLE -> CLEAR when clr_req=1.
  - At the same edge: all pending bits cleared and counter loaded with 0.
  - CLEAR: each cycle writes 0 to array[counter], then counter increments.
  - CLEAR -> IDLE after the edge that clears entry DEPTH-1.
- clr_busy = (state==CLEAR); high for exactly DEPTH cycles starting the cycle after clr_req.
- During CLEAR: wr_en, rsv_en and clr_req are ignored (dropped, not queued).
- During CLEAR, reads return current contents: cleared entries read 0, uncleared entries keep their old values.
- Counter is ADDR_W bits; the wrap at DEPTH-1 is the exit condition, not an error.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: a read whose address matches an enabled, accepted write in the same cycle returns that wr_data combinationally, using the highest matching port index.
- Defined: that read's rd_pend is forced to 0, unless rsv_en targets the same address.
- Bypass never applies to address 0 when ZERO_REG=1, and never during CLEAR.
- Undefined: reads return the pre-write array contents; rd_pend reflects the registered bits only.

Decomposition:
- Package rf_pkg: clear-state enum type (IDLE, CLEAR); localparam helper function for ADDR_W.
- Sub-module rf_scoreboard: pending-bit vector with set/clear priority and per-port lookup, instantiated once in rf_mp.

Test Plan:
- Reset then write 0xDEADBEEF to entry 5, read both ports at 5 -> 0 during the write cycle, 0xDEADBEEF the next cycle, rd_pend=0.
- Write 0x1234 to entry 0 with ZERO_REG=1 -> entry 0 reads 0 on every port in all later cycles.
- NUM_WR=2, both ports write entry 7 (port0=0xAAAA, port1=0x5555) -> entry 7 reads 0x5555.
- rsv_en at entry 3, next cycle rd_addr=3 -> rd_pend=1; write entry 3 -> rd_pend=0 the next cycle; reserve+write entry 3 in the same cycle -> rd_pend stays 1.
- Fill all entries with nonzero data, pulse clr_req -> clr_busy high for 32 cycles; entry k reads 0 from cycle k+2 after the pulse; a write to entry 31 at cycle 10 is dropped; all pending bits are 0.
- With RF_BYPASS_EN, write 0xCAFE to entry 9 while reading entry 9 -> rd_data=0xCAFE the same cycle. Without the macro -> old value.
